// File: rtl/register_file_param.sv
// Parameterised register file: two registered read ports, one write port,
// optional hardwired-zero register 0, optional write-to-read forwarding,
// and a sequenced clear that zeroes one register per cycle.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   rs, rt          - read addresses for readreg1 / readreg2
//   rd, write_data  - write address and data
//   write_enable    - write request (ignored while clearing)
//   read_enable     - update read outputs this edge; otherwise they hold
//   clr_req         - start a clear sweep (ignored while clearing)
//   readreg1/2      - registered read data
//   busy            - high while a clear sweep is in progress
//   clr_done        - one-cycle pulse after the last register is cleared
module register_file_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_enable,
  input  logic              read_enable,
  input  logic              clr_req,
  output logic [DATA_W-1:0] readreg1,
  output logic [DATA_W-1:0] readreg2,
  output logic              busy,
  output logic              clr_done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DATA_W-1:0] rr1_q, rr1_d;
  logic [DATA_W-1:0] rr2_q, rr2_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              wr_ok_c;
  logic [DATA_W-1:0] rd1_c, rd2_c;

  // Read data as seen this cycle, including forwarding of a same-cycle write.
  // Register 0 forced to zero last so it wins over forwarding.
  always_comb begin : read_mux
    wr_ok_c = write_enable && !((ZERO_REG != 0) && (rd == '0));
    rd1_c   = regs_q[rs];
    rd2_c   = regs_q[rt];
    if ((BYPASS != 0) && wr_ok_c && (rd == rs)) rd1_c = write_data;
    if ((BYPASS != 0) && wr_ok_c && (rd == rt)) rd2_c = write_data;
    if ((ZERO_REG != 0) && (rs == '0)) rd1_c = '0;
    if ((ZERO_REG != 0) && (rt == '0)) rd2_c = '0;
  end

  // State register and all output/storage flops.
  always_ff @(posedge clk or posedge rst) begin : seq
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rr1_q   <= '0;
      rr2_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr1_q   <= rr1_d;
      rr2_q   <= rr2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 0; i < int'(DEPTH); i++) regs_q[i] <= regs_d[i];
    end
  end

  // Next state and sweep index; the sweep stops at the last register.
  always_comb begin : next_state
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end
      end
      S_CLEAR: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Storage updates and registered outputs.
  always_comb begin : outputs
    for (int i = 0; i < int'(DEPTH); i++) regs_d[i] = regs_q[i];
    rr1_d  = rr1_q;
    rr2_d  = rr2_q;
    busy_d = (state_d == S_CLEAR);
    done_d = (state_q == S_CLEAR) && (state_d == S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (wr_ok_c) regs_d[rd] = write_data;
        if (read_enable) begin
          rr1_d = rd1_c;
          rr2_d = rd2_c;
        end
      end
      S_CLEAR: begin
        regs_d[idx_q] = '0;
        if (read_enable) begin
          rr1_d = '0;
          rr2_d = '0;
        end
      end
      default: ;
    endcase
  end

  assign readreg1 = rr1_q;
  assign readreg2 = rr2_q;
  assign busy     = busy_q;
  assign clr_done = done_q;

endmodule

// File: doc/register_file_param.md
REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set register and data-port width in bits (legal 8..64).
REQ-002 Parameter ADDR_W, default 5, SHALL set address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1, SHALL when 1 hardwire register 0 to zero.
REQ-004 Parameter BYPASS, default 1, SHALL when 1 enable write-to-read forwarding.
REQ-005 clk  input  1  SHALL be the single clock; all state changes on rising edge except reset.
REQ-006 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-007 rs  input  ADDR_W  SHALL be read port 1 address.
REQ-008 rt  input  ADDR_W  SHALL be read port 2 address.
REQ-009 rd  input  ADDR_W  SHALL be write address.
REQ-010 write_data  input  DATA_W  SHALL be write data.
REQ-011 write_enable  input  1  SHALL request a write of write_data to rd this cycle.
REQ-012 read_enable  input  1  SHALL, when high, update both read outputs; when low, outputs hold.
REQ-013 clr_req  input  1  SHALL request a sequenced clear of all registers.
REQ-014 readreg1  output  DATA_W  SHALL be registered read data for rs.
REQ-015 readreg2  output  DATA_W  SHALL be registered read data for rt.
REQ-016 busy  output  1  SHALL be high while a clear sequence is in progress.
REQ-017 clr_done  output  1  SHALL pulse high for one cycle when a clear sequence completes.

Function
REQ-018 Write: write_enable=1 in IDLE SHALL store write_data into register rd at the rising edge.
REQ-019 ZERO_REG=1: writes to address 0 SHALL be discarded; reads of address 0 SHALL return 0.
REQ-020 Read latency SHALL be one cycle: readreg1/2 at edge N+1 reflect rs/rt sampled at edge N with read_enable=1.
REQ-021 Same-cycle write and read to the same address, BYPASS=1: read output SHALL return the new write_data (ZERO_REG rule takes precedence).
REQ-022 Same-cycle write and read to the same address, BYPASS=0: read output SHALL return the value held before the write.
REQ-023 rs==rt SHALL return identical data on both outputs, including under bypass.
REQ-024 FSM states SHALL be IDLE and CLEAR; reset state IDLE.
REQ-025 IDLE with clr_req=1 SHALL transition to CLEAR next edge, sweep index loaded to 0, busy=1.
REQ-026 CLEAR SHALL write 0 to register[index] each cycle and increment index; index DEPTH-1 cleared -> IDLE next edge, clr_done=1 for that one cycle, busy=0.
REQ-027 A clear sequence SHALL take exactly DEPTH cycles with busy high.
REQ-028 In CLEAR, write_enable SHALL be ignored (write dropped, no queueing) and clr_req SHALL be ignored.
REQ-029 In CLEAR with read_enable=1, readreg1/2 SHALL load 0; with read_enable=0 they hold.
REQ-030 clr_req and write_enable asserted together in IDLE: the write SHALL complete that edge, then the clear SHALL begin (write is subsequently zeroed).
REQ-031 Sweep index SHALL be ADDR_W bits and SHALL NOT wrap into a second sweep.

Reset
REQ-032 rst high SHALL immediately force all DEPTH registers, readreg1, readreg2, sweep index to 0, busy=0, clr_done=0, state IDLE.
REQ-033 rst asserted mid-clear SHALL abort the sequence with no clr_done pulse; after release the block SHALL be in IDLE, all registers zero.
REQ-034 First edge after rst deassertion SHALL accept writes and reads normally.

Verification
REQ-035 Write 0xDEADBEEF to r5, next cycle rs=5 read_enable=1 -> readreg1=0xDEADBEEF one cycle later.
REQ-036 Write 0x12345678 to r0 (ZERO_REG=1), read rs=0 -> readreg1=0x00000000.
REQ-037 Same cycle write 0xA5A5A5A5 to r7, rs=rt=7 (r7 previously 0x1) -> both outputs 0xA5A5A5A5 with BYPASS=1, 0x00000001 with BYPASS=0.
REQ-038 Fill r1..r31 with index value, pulse clr_req -> busy high exactly 32 cycles, write to r3 during busy dropped, clr_done one-cycle pulse, all reads return 0 afterwards.
REQ-039 Assert rst at clear cycle 10 -> busy=0 and outputs 0 immediately, no clr_done, all registers read 0 after release.
REQ-040 read_enable=0 with changing rs/rt and writes -> readreg1/2 hold previous values.
